// File: rtl/core_ws_seq_pkg.sv
// Shared types and instruction-word layout for the weight-stationary sequencer.
// Optional run-cycle counter is enabled by CORE_WS_SEQ_PERF_CNT_EN in the top.
package core_ws_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WFETCH  = 3'd1,
        S_WLOAD   = 3'd2,
        S_ACT     = 3'd3,
        S_READOUT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int B_ALL_ROW_MODE = 37;
    localparam int B_L0_RD_MODE   = 36;
    localparam int B_MODE         = 35;
    localparam int B_DATA_MODE    = 34;
    localparam int B_ACC          = 33;
    localparam int B_CEN_PMEM     = 32;
    localparam int B_WEN_PMEM     = 31;
    localparam int B_A_PMEM_HI    = 30;
    localparam int B_A_PMEM_LO    = 20;
    localparam int B_CEN_XMEM     = 19;
    localparam int B_WEN_XMEM     = 18;
    localparam int B_A_XMEM_HI    = 17;
    localparam int B_A_XMEM_LO    = 7;
    localparam int B_OFIFO_RD     = 6;
    localparam int B_IFIFO_WR     = 5;
    localparam int B_IFIFO_RD     = 4;
    localparam int B_L0_RD        = 3;
    localparam int B_L0_WR        = 2;
    localparam int B_EXECUTE      = 1;
    localparam int B_LOAD         = 0;

    // SRAMs deselected and write-disabled, core left in mode 1
    localparam logic [37:0] IDLE_INST =
        (38'd1 << B_MODE)     |
        (38'd1 << B_CEN_PMEM) |
        (38'd1 << B_WEN_PMEM) |
        (38'd1 << B_CEN_XMEM) |
        (38'd1 << B_WEN_XMEM);

endpackage

// File: rtl/core_ws_sequencer_seq_step_counter.sv
// Loadable up-counter with a terminal-count compare, used for phase
// cycle counting and for the output-FIFO read count.
module seq_step_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/core_ws_sequencer.sv
// Weight-stationary run controller producing the core instruction word.
// Define CORE_WS_SEQ_PERF_CNT_EN to add the run_cycles busy counter.
module core_ws_sequencer
    import core_ws_seq_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int INST_W = 38
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] n_act,
    input  logic              ofifo_valid,
`ifdef CORE_WS_SEQ_PERF_CNT_EN
    output logic [31:0]       run_cycles,
`endif
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    state_t              r_state;
    state_t              w_nstate;
    logic [ADDR_W-1:0]   r_wbase;
    logic [ADDR_W-1:0]   r_xbase;
    logic [ADDR_W-1:0]   r_nact;
    logic [INST_W-1:0]   r_inst;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_phase_ld;
    logic                w_phase_en;
    logic [ADDR_W-1:0]   w_ph_cnt;
    logic [ADDR_W-1:0]   w_ph_term;
    logic                w_ph_hit;
    logic [ADDR_W-1:0]   w_ncnt;
    logic [ADDR_W-1:0]   w_rd_cnt;
    logic                w_rd_hit;
    logic                w_ofifo_rd;
    logic [ADDR_W-1:0]   w_wb;
    logic [INST_W-1:0]   w_ninst;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_phase_ld = (w_nstate != r_state);
    assign w_phase_en = (r_state != S_IDLE);
    assign w_ncnt     = w_phase_ld ? '0 : w_ph_cnt + 1'b1;
    assign w_wb       = (r_state == S_IDLE) ? w_base : r_wbase;

    // FIFO read is qualified by the live valid so no result is skipped
    assign w_ofifo_rd = (r_state == S_READOUT) && ofifo_valid
                        && (w_rd_cnt < r_nact);

    always_comb begin
        w_ph_term = '0;
        unique case (r_state)
            S_WFETCH: w_ph_term = ADDR_W'(ROW);
            S_WLOAD:  w_ph_term = ADDR_W'(ROW + COL - 2);
            S_ACT:    w_ph_term = r_nact;
            default:  w_ph_term = '0;
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_nstate = S_WFETCH;
            end
            S_WFETCH: begin
                if (w_ph_hit) w_nstate = S_WLOAD;
            end
            S_WLOAD: begin
                if (w_ph_hit)
                    w_nstate = (r_nact != '0) ? S_ACT : S_DONE;
            end
            S_ACT: begin
                if (w_ph_hit) w_nstate = S_READOUT;
            end
            S_READOUT: begin
                if (w_ofifo_rd && w_rd_hit) w_nstate = S_DONE;
            end
            S_DONE:  w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_ninst = IDLE_INST;
        unique case (w_nstate)
            S_WFETCH: begin
                w_ninst[B_DATA_MODE] = 1'b1;
                if (w_ncnt < ADDR_W'(ROW)) begin
                    w_ninst[B_CEN_PMEM] = 1'b0;
                    w_ninst[B_A_PMEM_HI:B_A_PMEM_LO] = w_wb + w_ncnt;
                end
                if (w_ncnt != '0) w_ninst[B_L0_WR] = 1'b1;
            end
            S_WLOAD: begin
                w_ninst[B_DATA_MODE] = 1'b1;
                w_ninst[B_LOAD]      = 1'b1;
                if (w_ncnt < ADDR_W'(ROW)) w_ninst[B_L0_RD] = 1'b1;
            end
            S_ACT: begin
                if (w_ncnt < r_nact) begin
                    w_ninst[B_CEN_XMEM] = 1'b0;
                    w_ninst[B_A_XMEM_HI:B_A_XMEM_LO] = r_xbase + w_ncnt;
                end
                if (w_ncnt != '0) begin
                    w_ninst[B_L0_WR]   = 1'b1;
                    w_ninst[B_L0_RD]   = 1'b1;
                    w_ninst[B_EXECUTE] = 1'b1;
                end
            end
            S_READOUT: begin
                w_ninst[B_EXECUTE] = 1'b1;
            end
            default: w_ninst = IDLE_INST;
        endcase
        w_ninst[B_ALL_ROW_MODE] = 1'b0;
        w_ninst[B_L0_RD_MODE]   = 1'b0;
        w_ninst[B_ACC]          = 1'b0;
        w_ninst[B_IFIFO_WR]     = 1'b0;
        w_ninst[B_IFIFO_RD]     = 1'b0;
        w_ninst[B_OFIFO_RD]     = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wbase <= '0;
            r_xbase <= '0;
            r_nact  <= '0;
            r_inst  <= IDLE_INST;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_inst  <= w_ninst;
            r_busy  <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
            r_done  <= (w_nstate == S_DONE);
            if (w_accept) begin
                r_wbase <= w_base;
                r_xbase <= x_base;
                r_nact  <= n_act;
            end
        end
    end

    seq_step_counter #(.W(ADDR_W)) u_phase_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .i_load (w_phase_ld),
        .i_val  ('0),
        .i_en   (w_phase_en),
        .i_term (w_ph_term),
        .o_cnt  (w_ph_cnt),
        .o_hit  (w_ph_hit)
    );

    seq_step_counter #(.W(ADDR_W)) u_rd_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .i_load (w_accept),
        .i_val  ('0),
        .i_en   (w_ofifo_rd),
        .i_term (r_nact - 1'b1),
        .o_cnt  (w_rd_cnt),
        .o_hit  (w_rd_hit)
    );

`ifdef CORE_WS_SEQ_PERF_CNT_EN
    logic [31:0] r_run_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_cycles <= '0;
        end else if (w_accept) begin
            r_run_cycles <= '0;
        end else if (r_busy && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + 1'b1;
        end
    end

    assign run_cycles = r_run_cycles;
`endif

    always_comb begin
        inst             = r_inst;
        inst[B_OFIFO_RD] = w_ofifo_rd;
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_core_ws_sequencer.sv
// Randomized self-checking bench for core_ws_sequencer against a
// phase-list reference model of the instruction stream.
module tb_core_ws_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [37:0] IDLE_W = 38'h9_800C_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] w_base;
    logic [10:0] x_base;
    logic [10:0] n_act;
    logic        ofifo_valid;
    logic [37:0] inst;
    logic        busy;
    logic        done;
`ifdef CORE_WS_SEQ_PERF_CNT_EN
    logic [31:0] run_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int bc    = 0;

    core_ws_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .n_act       (n_act),
        .ofifo_valid (ofifo_valid),
`ifdef CORE_WS_SEQ_PERF_CNT_EN
        .run_cycles  (run_cycles),
`endif
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (busy === 1'b1) bc <= bc + 1;

    task automatic run_seq(input logic [10:0] wb, input logic [10:0] xb,
                           input logic [10:0] n, input int vprob,
                           input logic [15:0] vpat, input bit use_pat,
                           input int inj, input bit done_start,
                           input string nm);
        logic [37:0] eq[$];
        logic [37:0] mq[$];
        logic [37:0] w;
        logic [37:0] m;
        int bc0, k, rd, cyc, exp_busy;
        bit v;
        m = '1;
        m[34] = 1'b0;
        for (int i = 0; i <= ROW; i++) begin
            w = IDLE_W;
            w[34] = 1'b1;
            if (i < ROW) begin
                w[32] = 1'b0;
                w[30:20] = wb + 11'(i);
            end
            if (i > 0) w[2] = 1'b1;
            eq.push_back(w);
            mq.push_back('1);
        end
        for (int i = 0; i < ROW + COL - 1; i++) begin
            w = IDLE_W;
            w[0] = 1'b1;
            if (i < ROW) w[3] = 1'b1;
            eq.push_back(w);
            mq.push_back(m);
        end
        if (n != 0) begin
            for (int j = 0; j <= int'(n); j++) begin
                w = IDLE_W;
                if (j < int'(n)) begin
                    w[19] = 1'b0;
                    w[17:7] = xb + 11'(j);
                end
                if (j > 0) begin
                    w[3] = 1'b1;
                    w[2] = 1'b1;
                    w[1] = 1'b1;
                end
                eq.push_back(w);
                mq.push_back('1);
            end
        end
        @(negedge clk);
        start = 1'b1;
        w_base = wb;
        x_base = xb;
        n_act = n;
        ofifo_valid = 1'($urandom_range(0, 1));
        bc0 = bc;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        foreach (eq[i]) begin
            ofifo_valid = 1'($urandom_range(0, 1));
            if (cyc == inj) begin
                start = 1'b1;
                w_base = ~wb;
                x_base = xb + 11'd37;
                n_act = n + 11'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            total++;
            if ((inst & mq[i]) !== (eq[i] & mq[i]) || busy !== 1'b1 ||
                done !== 1'b0) begin
                bad++;
                $display("FAIL %s run cyc=%0d inst=%h busy=%b done=%b want inst=%h busy=1 done=0",
                         nm, cyc, inst, busy, done, eq[i]);
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        rd = 0;
        k = 0;
        while (n != 0 && rd < int'(n) && k < 300) begin
            if (use_pat && k < 16) v = vpat[k];
            else v = ($urandom_range(0, 99) < vprob);
            ofifo_valid = v;
            w = IDLE_W;
            w[1] = 1'b1;
            w[6] = v;
            #1;
            total++;
            if ((inst & m) !== (w & m) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s readout k=%0d inst=%h busy=%b done=%b want inst=%h busy=1",
                         nm, k, inst, busy, done, w);
            end
            if (v) rd++;
            k++;
            @(negedge clk);
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL %s readout_timeout reads=%0d want %0d", nm, rd, n);
        end
        ofifo_valid = 1'b1;
        if (done_start) begin
            start = 1'b1;
            w_base = wb + 11'd3;
        end
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_cycle inst=%h busy=%b done=%b want inst=%h busy=0 done=1",
                     nm, inst, busy, done, IDLE_W);
        end
        exp_busy = (ROW + 1) + (ROW + COL - 1) + ((n != 0) ? int'(n) + 1 + k : 0);
        total++;
        if (bc - bc0 != exp_busy) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", nm, bc - bc0, exp_busy);
        end
`ifdef CORE_WS_SEQ_PERF_CNT_EN
        total++;
        if (run_cycles !== 32'(exp_busy)) begin
            bad++;
            $display("FAIL %s run_cycles got=%0d want=%0d", nm, run_cycles, exp_busy);
        end
`endif
        @(negedge clk);
        start = 1'b0;
        ofifo_valid = 1'b0;
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
                     nm, inst, busy, done, IDLE_W);
        end
        if (done_start) begin
            @(negedge clk);
            #1;
            total++;
            if (inst !== IDLE_W || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s start_in_done inst=%h busy=%b want idle busy=0",
                         nm, inst, busy);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        w_base = 11'd0;
        x_base = 11'd0;
        n_act = 11'd0;
        ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
                     inst, busy, done, IDLE_W);
        end
        @(negedge clk);
        start = 1'b0;
        ofifo_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release inst=%h busy=%b want idle", inst, busy);
        end
    endtask

    task automatic test_basic;
        run_seq(11'd16, 11'd100, 11'd4, 100, 16'h0, 1'b0, -1, 1'b0, "basic");
    endtask

    task automatic test_zero_act;
        run_seq(11'd500, 11'd7, 11'd0, 100, 16'h0, 1'b0, -1, 1'b0, "zero_act");
    endtask

    task automatic test_wrap;
        run_seq(11'd2046, 11'd2045, 11'd5, 60, 16'h0, 1'b0, -1, 1'b0, "wrap");
    endtask

    task automatic test_valid_toggle;
        run_seq(11'd40, 11'd200, 11'd3, 50, 16'b11001, 1'b1, -1, 1'b0, "valid_toggle");
    endtask

    task automatic test_start_ignored;
        run_seq(11'd64, 11'd900, 11'd6, 80, 16'h0, 1'b0,
                (ROW + 1) + (ROW + COL - 1) + 2, 1'b1, "start_ignored");
    endtask

    task automatic test_midrun_reset;
        @(negedge clk);
        start = 1'b1;
        w_base = 11'd300;
        x_base = 11'd5;
        n_act = 11'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (ROW + 1 + 4) @(negedge clk);
        #1;
        total++;
        if (inst[0] !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_in_wload load=%b busy=%b want 1 1", inst[0], busy);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset inst=%h busy=%b done=%b want inst=%h busy=0 done=0",
                     inst, busy, done, IDLE_W);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (inst !== IDLE_W || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_after_release inst=%h busy=%b want idle", inst, busy);
        end
        run_seq(11'd1000, 11'd33, 11'd4, 70, 16'h0, 1'b0, -1, 1'b0, "post_reset");
    endtask

    task automatic test_random;
        logic [10:0] wb;
        logic [10:0] xb;
        logic [10:0] n;
        for (int r = 0; r < 6; r++) begin
            wb = 11'($urandom);
            xb = 11'($urandom);
            n = 11'($urandom_range(0, 12));
            run_seq(wb, xb, n, int'($urandom_range(30, 100)), 16'h0, 1'b0,
                    -1, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_act;
        test_wrap;
        test_valid_toggle;
        test_start_ignored;
        test_midrun_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_ws_sequencer.md
Name: core_ws_sequencer

Overview:
Weight-stationary run controller that drives the 38-bit `inst` word of the `core` block.
- Per run it fetches ROW weight rows from pmem into L0, then pushes them into the PE array.
- It then streams `n_act` activation vectors from xmem through L0 with `execute`.
- Finally it drains the output FIFO by asserting `ofifo_rd` once per result.
- It sits between the host/testbench command interface and `core`.

Parameters:
ROW, 8, PE array rows / weight rows fetched per run
COL, 8, PE array columns; sets the load propagation length
ADDR_W, 11, SRAM address width
INST_W, 38, width of the core instruction word

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle run request, sampled only in IDLE
w_base  input  ADDR_W  pmem address of weight row 0, captured on accepted start
x_base  input  ADDR_W  xmem address of activation 0, captured on accepted start
n_act  input  ADDR_W  activation vector count, captured on accepted start
ofifo_valid  input  1  core output FIFO has data
inst  output  INST_W  registered instruction word to core
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle pulse at end of run

Behaviour:
- Instruction field map:
  - [37] all_row_mode, [36] l0_rd_mode, [35] mode, [34] data_mode, [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- CEN and WEN are active-low.
- IDLE word: CEN_pmem = WEN_pmem = CEN_xmem = WEN_xmem = 1, mode = 1, every other bit 0.
- Constant for the whole run: mode = 1, acc = 0, all_row_mode = 0, l0_rd_mode = 0, ififo_wr = ififo_rd = 0, WEN_pmem = WEN_xmem = 1.
- The sequencer never writes SRAM.
- Reset (async, active-low): state goes to IDLE; inst = IDLE word; busy = 0; done = 0; all counters cleared.
  - Reset mid-run aborts the run immediately; no recovery cycle.
- inst is registered. The SRAM read latency is 1 cycle, so `l0_wr` is asserted in the cycle after the matching CEN = 0.
- States and transitions:
  - IDLE: start = 1 → capture w_base, x_base, n_act; go to WFETCH. busy rises next cycle.
  - WFETCH (ROW+1 cycles, data_mode = 1):
    - Cycles 0..ROW-1: CEN_pmem = 0, A_pmem = w_base + i.
    - Cycles 1..ROW: l0_wr = 1.
    - Next state: WLOAD.
  - WLOAD (ROW+COL-1 cycles): load = 1 throughout; l0_rd = 1 for the first ROW cycles.
    - Next state: ACT if n_act ≠ 0, else DONE.
  - ACT (n_act+1 cycles, data_mode = 0):
    - Cycles 0..n_act-1: CEN_xmem = 0, A_xmem = x_base + j.
    - Cycles 1..n_act: l0_wr = 1, l0_rd = 1, execute = 1.
    - Next state: READOUT.
  - READOUT:
    - execute stays 1.
    - ofifo_rd = 1 only in cycles where ofifo_valid = 1 and rd_cnt < n_act.
    - rd_cnt increments on each ofifo_rd.
    - When rd_cnt reaches n_act: go to DONE.
  - DONE (1 cycle): done = 1, busy = 0, inst = IDLE word; next state IDLE.
- Addresses wrap modulo 2^ADDR_W (e.g. base 2046 + 3 → address 1).
- n_act = 0: skip ACT and READOUT; ofifo_rd is never asserted.
- start while busy, or start in DONE: ignored; captured inputs stay unchanged.
- ofifo_valid while not in READOUT: ignored.
- READOUT has no timeout; the bench must supply ofifo_valid.

Optional Feature:
- Macro: CORE_WS_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output run_cycles[31:0].
  - Counter clears on accepted start and increments every busy cycle.
  - Holds its value after done until the next start.
  - Saturates at 2^32-1.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package core_ws_seq_pkg holds:
  - state enum: IDLE, WFETCH, WLOAD, ACT, READOUT, DONE
  - inst bit-index localparams for every field
  - IDLE_INST constant
- One sub-module, seq_step_counter:
  - loadable up-counter with terminal-count compare
  - instanced for the phase cycle count and for rd_cnt

Test Plan:
- Reset, then start with w_base=16, x_base=100, n_act=4, ofifo_valid held 1:
  - A_pmem 16..23 with CEN_pmem low for 8 cycles; l0_wr lags by 1.
  - load high for 15 cycles.
  - A_xmem 100..103 with execute high for 4 cycles.
  - Exactly 4 ofifo_rd pulses; done pulses; total busy cycles = 9+15+5+4.
- n_act=0 → no CEN_xmem low and no ofifo_rd; done the cycle after WLOAD ends.
- w_base=2046 → A_pmem sequence 2046, 2047, 0..5.
- n_act=3, ofifo_valid toggling 1,0,0,1,1 → ofifo_rd only in the valid cycles; exactly 3 reads; then done.
- Start asserted during ACT with different bases → ignored; addresses continue from the original base.
- reset low mid-WLOAD → inst equals IDLE_INST in the same cycle, busy=0; a later start runs a clean full sequence.
